// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: op codes, FSM state encodings and stack direction constants for pc_sequencer.
package pc_seq_pkg;
  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;
  localparam logic [1:0] ST_RUN  = 2'b00;
  localparam logic [1:0] ST_POP  = 2'b01;
  localparam logic [1:0] ST_LOAD = 2'b10;
  localparam logic [1:0] ST_HALT = 2'b11;
  localparam logic STK_PUSH = 1'b0;
  localparam logic STK_POP  = 1'b1;
endpackage

// File: rtl/pc_sequencer_if.sv
// pc_seq_if: decoder-side op strobe and return-stack bus of pc_sequencer; slave = sequencer, master = driver.
interface pc_seq_if #(parameter int AW = 8, parameter int DEPTH_LOG2 = 2);
  logic                  step;
  logic [1:0]            op;
  logic [AW-1:0]         target;
  logic                  halt_req;
  logic [AW-1:0]         stk_q;
  logic [AW-1:0]         pc;
  logic                  stk_en;
  logic                  stk_con;
  logic [AW-1:0]         stk_data;
  logic [DEPTH_LOG2:0]   depth;
  logic                  busy;
  logic                  halted;
  logic                  fault;
  modport master (output step, op, target, halt_req, stk_q,
                  input  pc, stk_en, stk_con, stk_data, depth, busy, halted, fault);
  modport slave  (input  step, op, target, halt_req, stk_q,
                  output pc, stk_en, stk_con, stk_data, depth, busy, halted, fault);
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter with CALL/RET return-stack control and occupancy tracking.
// Define PC_STACK_TRAP_EN to halt on stack overflow/underflow instead of continuing.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int AW = 8,
  parameter int DEPTH_LOG2 = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic    clk,
  input logic    clr,
  pc_seq_if.slave bus
);
  localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  logic [1:0]          state_q, state_d;
  logic [AW-1:0]       pc_q, pc_d, data_q, data_d, pc_inc;
  logic                en_q, en_d, con_q, con_d, fault_q, fault_d;
  logic                busy_q, busy_d, halted_q, halted_d;
  logic [DEPTH_LOG2:0] depth_q, depth_d;
  logic                push, pop;
  assign pc_inc = pc_q + 1'b1;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    en_d    = 1'b0;
    con_d   = con_q;
    data_d  = data_q;
    fault_d = fault_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      ST_RUN: if (bus.step) begin
        if (bus.halt_req) state_d = ST_HALT;
        else case (bus.op)
          OP_SEQ:  pc_d = pc_inc;
          OP_JUMP: pc_d = bus.target;
          OP_CALL: if (depth_q != FULL) begin
            push   = 1'b1;
            pc_d   = bus.target;
            en_d   = 1'b1;
            con_d  = STK_PUSH;
            data_d = pc_inc;
          end else begin
            fault_d = 1'b1;
`ifdef PC_STACK_TRAP_EN
            state_d = ST_HALT;
`else
            pc_d = bus.target;
`endif
          end
          default: if (depth_q != '0) begin
            pop     = 1'b1;
            en_d    = 1'b1;
            con_d   = STK_POP;
            state_d = ST_POP;
          end else begin
            fault_d = 1'b1;
`ifdef PC_STACK_TRAP_EN
            state_d = ST_HALT;
`else
            pc_d = pc_inc;
`endif
          end
        endcase
      end
      ST_POP: state_d = ST_LOAD;
      // stk_q holds the pop result registered by the stack on the POP edge
      ST_LOAD: begin
        pc_d    = bus.stk_q;
        state_d = ST_RUN;
      end
      default: ;
    endcase
    busy_d   = (state_d == ST_POP) || (state_d == ST_LOAD);
    halted_d = state_d == ST_HALT;
  end
  always_comb depth_d = push ? depth_q + 1'b1 : pop ? depth_q - 1'b1 : depth_q;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_PC;
      en_q     <= 1'b0;
      con_q    <= STK_PUSH;
      data_q   <= '0;
      fault_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      en_q     <= en_d;
      con_q    <= con_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) depth_q <= '0;
    else depth_q <= depth_d;
  end
  assign bus.pc       = pc_q;
  assign bus.stk_en   = en_q;
  assign bus.stk_con  = con_q;
  assign bus.stk_data = data_q;
  assign bus.depth    = depth_q;
  assign bus.busy     = busy_q;
  assign bus.halted   = halted_q;
  assign bus.fault    = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed table, corner sequences and random ops checked against a queue-based model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;
  logic clk = 1'b0;
  logic clr = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  pc_seq_if #(.AW(8), .DEPTH_LOG2(2)) bus();
  pc_sequencer #(.AW(8), .DEPTH_LOG2(2), .RESET_PC(8'h00)) dut (.clk(clk), .clr(clr), .bus(bus));
  // return-address stack with registered pop output
  logic [7:0] smem [4];
  int sp = 0;
  always @(posedge clk) begin
    if (clr) sp <= 0;
    else if (bus.stk_en) begin
      if (bus.stk_con) begin
        bus.stk_q <= smem[2'(sp - 1)];
        sp <= sp - 1;
      end else begin
        smem[2'(sp)] <= bus.stk_data;
        sp <= sp + 1;
      end
    end
  end
  typedef struct {
    logic       step;
    logic [1:0] op;
    logic [7:0] tgt;
    logic [7:0] pc;
    logic       en;
    logic       con;
    logic [7:0] data;
    logic [2:0] depth;
    logic       busy;
  } vec_t;
  vec_t vt[$];
  logic [7:0] m_pc, m_ret, m_data;
  logic       m_en, m_con, m_fault, m_halt;
  int         m_busy;
  logic [7:0] m_stk[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask
  task automatic cyc(input logic s, input logic [1:0] o, input logic [7:0] t, input logic h);
    bus.step = s;
    bus.op = o;
    bus.target = t;
    bus.halt_req = h;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    bus.step = 1'b0;
    bus.halt_req = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #2;
    clr = 1'b0;
    #1;
  endtask
  task automatic model_step(input logic s, input logic [1:0] o, input logic [7:0] t, input logic h);
    m_en = 1'b0;
    if (m_halt) ;
    else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) m_pc = m_ret;
    end else if (s) begin
      if (h) m_halt = 1'b1;
      else if (o == OP_SEQ) m_pc = m_pc + 8'd1;
      else if (o == OP_JUMP) m_pc = t;
      else if (o == OP_CALL) begin
        if (m_stk.size() < 4) begin
          m_data = m_pc + 8'd1;
          m_stk.push_back(m_data);
          m_pc = t;
          m_en = 1'b1;
          m_con = 1'b0;
        end else begin
          m_fault = 1'b1;
`ifdef PC_STACK_TRAP_EN
          m_halt = 1'b1;
`else
          m_pc = t;
`endif
        end
      end else begin
        if (m_stk.size() > 0) begin
          m_ret = m_stk.pop_back();
          m_busy = 2;
          m_en = 1'b1;
          m_con = 1'b1;
        end else begin
          m_fault = 1'b1;
`ifdef PC_STACK_TRAP_EN
          m_halt = 1'b1;
`else
          m_pc = m_pc + 8'd1;
`endif
        end
      end
    end
  endtask
  task automatic chk_model(input int i);
    chk($sformatf("rnd%0d_pc", i), 32'(bus.pc), 32'(m_pc));
    chk($sformatf("rnd%0d_en", i), 32'(bus.stk_en), 32'(m_en));
    if (m_en) chk($sformatf("rnd%0d_con", i), 32'(bus.stk_con), 32'(m_con));
    if (m_en && !m_con) chk($sformatf("rnd%0d_data", i), 32'(bus.stk_data), 32'(m_data));
    chk($sformatf("rnd%0d_depth", i), 32'(bus.depth), 32'(m_stk.size()));
    chk($sformatf("rnd%0d_busy", i), 32'(bus.busy), 32'(m_busy > 0));
    chk($sformatf("rnd%0d_halted", i), 32'(bus.halted), 32'(m_halt));
    chk($sformatf("rnd%0d_fault", i), 32'(bus.fault), 32'(m_fault));
  endtask
  initial begin
    logic s, h;
    logic [1:0] o;
    logic [7:0] t;
    bus.step = 1'b0;
    bus.op = OP_SEQ;
    bus.target = 8'h00;
    bus.halt_req = 1'b0;
    vt.push_back('{1'b1, OP_SEQ,  8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
    vt.push_back('{1'b1, OP_SEQ,  8'h00, 8'h02, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
    vt.push_back('{1'b1, OP_SEQ,  8'h00, 8'h03, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
    vt.push_back('{1'b1, OP_JUMP, 8'h10, 8'h10, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
    vt.push_back('{1'b1, OP_CALL, 8'h40, 8'h40, 1'b1, 1'b0, 8'h11, 3'd1, 1'b0});
    vt.push_back('{1'b0, OP_SEQ,  8'h00, 8'h40, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0});
    vt.push_back('{1'b1, OP_RET,  8'h00, 8'h40, 1'b1, 1'b1, 8'h00, 3'd0, 1'b1});
    vt.push_back('{1'b1, OP_SEQ,  8'h00, 8'h40, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1});
    vt.push_back('{1'b0, OP_SEQ,  8'h00, 8'h11, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
    vt.push_back('{1'b1, OP_CALL, 8'h20, 8'h20, 1'b1, 1'b0, 8'h12, 3'd1, 1'b0});
    vt.push_back('{1'b1, OP_CALL, 8'h30, 8'h30, 1'b1, 1'b0, 8'h21, 3'd2, 1'b0});
    vt.push_back('{1'b1, OP_CALL, 8'h50, 8'h50, 1'b1, 1'b0, 8'h31, 3'd3, 1'b0});
    vt.push_back('{1'b1, OP_RET,  8'h00, 8'h50, 1'b1, 1'b1, 8'h00, 3'd2, 1'b1});
    vt.push_back('{1'b0, OP_SEQ,  8'h00, 8'h50, 1'b0, 1'b0, 8'h00, 3'd2, 1'b1});
    vt.push_back('{1'b0, OP_SEQ,  8'h00, 8'h31, 1'b0, 1'b0, 8'h00, 3'd2, 1'b0});
    vt.push_back('{1'b1, OP_RET,  8'h00, 8'h31, 1'b1, 1'b1, 8'h00, 3'd1, 1'b1});
    vt.push_back('{1'b1, OP_JUMP, 8'h77, 8'h31, 1'b0, 1'b0, 8'h00, 3'd1, 1'b1});
    vt.push_back('{1'b0, OP_SEQ,  8'h00, 8'h21, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0});
    vt.push_back('{1'b1, OP_RET,  8'h00, 8'h21, 1'b1, 1'b1, 8'h00, 3'd0, 1'b1});
    vt.push_back('{1'b0, OP_SEQ,  8'h00, 8'h21, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1});
    vt.push_back('{1'b0, OP_SEQ,  8'h00, 8'h12, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
    vt.push_back('{1'b1, OP_JUMP, 8'hFF, 8'hFF, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
    vt.push_back('{1'b1, OP_SEQ,  8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0});
    do_reset();
    chk("rst_pc", 32'(bus.pc), 32'h00);
    chk("rst_en", 32'(bus.stk_en), 32'h0);
    chk("rst_con", 32'(bus.stk_con), 32'h0);
    chk("rst_data", 32'(bus.stk_data), 32'h00);
    chk("rst_depth", 32'(bus.depth), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    for (int i = 0; i < vt.size(); i++) begin
      cyc(vt[i].step, vt[i].op, vt[i].tgt, 1'b0);
      chk($sformatf("tbl%0d_pc", i), 32'(bus.pc), 32'(vt[i].pc));
      chk($sformatf("tbl%0d_en", i), 32'(bus.stk_en), 32'(vt[i].en));
      if (vt[i].en) chk($sformatf("tbl%0d_con", i), 32'(bus.stk_con), 32'(vt[i].con));
      if (vt[i].en && !vt[i].con) chk($sformatf("tbl%0d_data", i), 32'(bus.stk_data), 32'(vt[i].data));
      chk($sformatf("tbl%0d_depth", i), 32'(bus.depth), 32'(vt[i].depth));
      chk($sformatf("tbl%0d_busy", i), 32'(bus.busy), 32'(vt[i].busy));
      chk($sformatf("tbl%0d_fault", i), 32'(bus.fault), 32'h0);
    end
    cyc(1'b1, OP_CALL, 8'h60, 1'b0);
    chk("wrap_push_data", 32'(bus.stk_data), 32'h01);
    do_reset();
    for (int i = 1; i <= 4; i++) cyc(1'b1, OP_CALL, 8'(i), 1'b0);
    chk("ovf_pre_depth", 32'(bus.depth), 32'h4);
    chk("ovf_pre_fault", 32'(bus.fault), 32'h0);
    cyc(1'b1, OP_CALL, 8'h05, 1'b0);
    chk("ovf_fault", 32'(bus.fault), 32'h1);
    chk("ovf_depth", 32'(bus.depth), 32'h4);
    chk("ovf_en", 32'(bus.stk_en), 32'h0);
`ifdef PC_STACK_TRAP_EN
    chk("ovf_pc", 32'(bus.pc), 32'h04);
    chk("ovf_halted", 32'(bus.halted), 32'h1);
`else
    chk("ovf_pc", 32'(bus.pc), 32'h05);
    chk("ovf_halted", 32'(bus.halted), 32'h0);
`endif
    cyc(1'b1, OP_SEQ, 8'h00, 1'b0);
    chk("ovf_sticky", 32'(bus.fault), 32'h1);
    do_reset();
    chk("clr_fault", 32'(bus.fault), 32'h0);
    cyc(1'b1, OP_RET, 8'h00, 1'b0);
    chk("unf_fault", 32'(bus.fault), 32'h1);
    chk("unf_en", 32'(bus.stk_en), 32'h0);
    chk("unf_busy", 32'(bus.busy), 32'h0);
    chk("unf_depth", 32'(bus.depth), 32'h0);
`ifdef PC_STACK_TRAP_EN
    chk("unf_pc", 32'(bus.pc), 32'h00);
    chk("unf_halted", 32'(bus.halted), 32'h1);
`else
    chk("unf_pc", 32'(bus.pc), 32'h01);
    chk("unf_halted", 32'(bus.halted), 32'h0);
`endif
    do_reset();
    cyc(1'b1, OP_CALL, 8'h40, 1'b0);
    cyc(1'b1, OP_RET, 8'h00, 1'b0);
    cyc(1'b0, OP_SEQ, 8'h00, 1'b0);
    chk("load_busy", 32'(bus.busy), 32'h1);
    #2;
    clr = 1'b1;
    #1;
    chk("midret_pc", 32'(bus.pc), 32'h00);
    chk("midret_busy", 32'(bus.busy), 32'h0);
    chk("midret_depth", 32'(bus.depth), 32'h0);
    @(posedge clk);
    #2;
    clr = 1'b0;
    cyc(1'b0, OP_SEQ, 8'h00, 1'b0);
    chk("midret_hold_pc", 32'(bus.pc), 32'h00);
    chk("midret_hold_busy", 32'(bus.busy), 32'h0);
    cyc(1'b1, OP_CALL, 8'h33, 1'b0);
    cyc(1'b1, OP_RET, 8'h00, 1'b1);
    chk("halt_halted", 32'(bus.halted), 32'h1);
    chk("halt_pc", 32'(bus.pc), 32'h33);
    chk("halt_en", 32'(bus.stk_en), 32'h0);
    cyc(1'b1, OP_CALL, 8'h99, 1'b0);
    cyc(1'b1, OP_SEQ, 8'h00, 1'b0);
    chk("halt_frozen_pc", 32'(bus.pc), 32'h33);
    chk("halt_frozen_depth", 32'(bus.depth), 32'h1);
    chk("halt_frozen_en", 32'(bus.stk_en), 32'h0);
    do_reset();
    m_pc = 8'h00;
    m_ret = 8'h00;
    m_data = 8'h00;
    m_en = 1'b0;
    m_con = 1'b0;
    m_fault = 1'b0;
    m_halt = 1'b0;
    m_busy = 0;
    m_stk.delete();
    for (int i = 0; i < 400; i++) begin
      s = $urandom_range(3) != 0;
      o = 2'($urandom_range(3));
      t = 8'($urandom);
      h = i == 399;
      model_step(s, o, t, h);
      cyc(s, o, t, h);
      chk_model(i);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
